// File: rtl/io_port.sv
// io_port: CPU I/O responder with input byte FIFO, output holding register and nSIG strobe decode.
// Optional IO_PORT_OVF_EN enables the sticky dropped-write flag ovf.
module io_port #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RD,
  input  logic       WR,
  input  logic [7:0] nSIG,
  input  logic [7:0] acc,
  output logic [7:0] rd_data,
  output logic       rd_empty,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic [5:0] sig_out,
  output logic       ovf
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [7:0] low;
  logic push, pop, flush, accept;
  // isolate the lowest active (low) strobe bit: ~n & -(~n) == ~n & (n + 1)
  assign low      = ~nSIG & (nSIG + 8'd1);
  assign flush    = low[1];
  assign rd_empty = cnt == '0;
  assign in_ready = cnt != (AW+1)'(DEPTH);
  assign push     = in_valid & in_ready;
  assign pop      = RD & ~rd_empty;
  assign accept   = WR & (~out_valid | out_ready);
  assign rd_data  = rd_empty ? 8'h00 : mem[rp];
  always_ff @(posedge clk)
    if (push) mem[flush ? '0 : wp] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      sig_out   <= 6'h00;
    end else begin
      sig_out   <= low[7:2];
      out_valid <= accept | (out_valid & ~out_ready);
      if (accept) out_data <= acc;
      if (flush) begin
        rp  <= '0;
        wp  <= push ? AW'(1) : '0;
        cnt <= push ? (AW+1)'(1) : '0;
      end else begin
        if (push) wp <= wp + AW'(1);
        if (pop) rp <= rp + AW'(1);
        cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
`ifdef IO_PORT_OVF_EN
  logic drop;
  assign drop = WR & out_valid & ~out_ready;
  always_ff @(posedge clk)
    if (rst) ovf <= 1'b0;
    else ovf <= drop | (ovf & ~low[0]);
`else
  logic unused_clr;
  assign unused_clr = low[0];
  assign ovf = 1'b0;
`endif
endmodule
